// File: rtl/uart_rx_monitor.sv
// Simulation-support UART receiver: deserialises 8N1 frames (optional parity)
// from a DUT TX line and reports each byte or line error as a one-cycle pulse.
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] uart_data,
    output logic       uart_data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);
    localparam int            TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    PAR_MODE  = 2'(PARITY);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic          sync1_r, rx_r, armed_r;
    logic [TW-1:0] timer_r, timer_s;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          par_mismatch_r;
    logic          half_hit_s, full_hit_s;
    logic          valid_s, frame_err_s, parity_err_s, busy_s;

    function automatic logic parity_mismatch(input logic [7:0] data, input logic pbit);
        logic ones_odd;
        ones_odd = ^{data, pbit};
        case (PAR_MODE)
            2'd1:    parity_mismatch = ~ones_odd;
            2'd2:    parity_mismatch = ones_odd;
            default: parity_mismatch = 1'b0;
        endcase
    endfunction

    assign half_hit_s = (timer_r == HALF_LAST);
    assign full_hit_s = (timer_r == FULL_LAST);

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            rx_r    <= 1'b1;
        end else begin
            sync1_r <= rxd;
            rx_r    <= sync1_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; IDLE only starts a frame once the line has been seen high.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!rx_r && armed_r) state_s = ST_START;
                else                  state_s = ST_IDLE;
            end
            ST_START: begin
                if (half_hit_s) state_s = rx_r ? ST_IDLE : ST_DATA;
                else            state_s = ST_START;
            end
            ST_DATA: begin
                if (full_hit_s && bit_idx_r == 3'd7)
                    state_s = (PAR_MODE != 2'd0) ? ST_PARITY : ST_STOP;
                else
                    state_s = ST_DATA;
            end
            ST_PARITY: begin
                if (full_hit_s) state_s = ST_STOP;
                else            state_s = ST_PARITY;
            end
            ST_STOP: begin
                if (full_hit_s) state_s = ST_IDLE;
                else            state_s = ST_STOP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Bit timer restarts on every state change and at each full bit period.
    always_comb begin
        timer_s = timer_r;
        if (state_r == ST_IDLE || state_s != state_r || full_hit_s) timer_s = '0;
        else                                                     timer_s = timer_r + TW'(1'b1);
    end

    // Frame datapath: timer, bit index, shift register, held parity result, re-arm flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r        <= '0;
            bit_idx_r      <= 3'd0;
            shift_r        <= 8'h00;
            par_mismatch_r <= 1'b0;
            armed_r        <= 1'b1;
        end else begin
            timer_r <= timer_s;
            if (state_r == ST_START)
                bit_idx_r <= 3'd0;
            else if (state_r == ST_DATA && full_hit_s)
                bit_idx_r <= bit_idx_r + 3'd1;
            if (state_r == ST_DATA && full_hit_s)
                shift_r <= {rx_r, shift_r[7:1]};
            if (state_r == ST_START)
                par_mismatch_r <= 1'b0;
            else if (state_r == ST_PARITY && full_hit_s)
                par_mismatch_r <= parity_mismatch(shift_r, rx_r);
            // A low stop bit (break) disarms start detection until the line goes high.
            if (state_r == ST_STOP && full_hit_s)
                armed_r <= rx_r;
            else if (rx_r)
                armed_r <= 1'b1;
        end
    end

    // Stop-bit outcome decode; frame error outranks parity error.
    always_comb begin
        busy_s       = (state_r != ST_IDLE);
        valid_s      = 1'b0;
        frame_err_s  = 1'b0;
        parity_err_s = 1'b0;
        if (state_r == ST_STOP && full_hit_s) begin
            if (!rx_r)               frame_err_s  = 1'b1;
            else if (par_mismatch_r) parity_err_s = 1'b1;
            else                     valid_s      = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
    end

    assign rx_busy = busy_s;

    // Registered result pulses; uart_data only changes with a valid byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_data       <= 8'h00;
            uart_data_valid <= 1'b0;
            frame_err       <= 1'b0;
            parity_err      <= 1'b0;
        end else begin
            uart_data_valid <= valid_s;
            frame_err       <= frame_err_s;
            parity_err      <= parity_err_s;
            if (valid_s) uart_data <= shift_r;
        end
    end
endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor: three instances (no/odd/even parity)
// driven by directed and random frames, checked against a frame-level model.
module tb_uart_rx_monitor;
    localparam int CLKS     = 16;
    localparam int K_VALID  = 1;
    localparam int K_FRAME  = 2;
    localparam int K_PARITY = 3;

    typedef struct {
        int         dut;
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       rxd_v    = 1'b1;
    int         line_sel = 0;
    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] last_data [3];
    ev_t        ev_q[$];
    ev_t        exp_q[$];

    logic       rxd_w   [3];
    logic [7:0] data_w  [3];
    logic       valid_w [3];
    logic       ferr_w  [3];
    logic       perr_w  [3];
    logic       busy_w  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance k has PARITY = k: 0 none, 1 odd, 2 even.
    for (genvar k = 0; k < 3; k++) begin : g_dut
        assign rxd_w[k] = (line_sel == k) ? rxd_v : 1'b1;
        uart_rx_monitor #(.CLKS_PER_BIT(CLKS), .PARITY(k)) dut (
            .clk             (clk),
            .reset           (reset),
            .rxd             (rxd_w[k]),
            .uart_data       (data_w[k]),
            .uart_data_valid (valid_w[k]),
            .frame_err       (ferr_w[k]),
            .parity_err      (perr_w[k]),
            .rx_busy         (busy_w[k])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (valid_w[k]) ev_q.push_back('{k, K_VALID, data_w[k], cyc});
            if (ferr_w[k])  ev_q.push_back('{k, K_FRAME, data_w[k], cyc});
            if (perr_w[k])  ev_q.push_back('{k, K_PARITY, data_w[k], cyc});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at limit 2000000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [55:0] ev_key(ev_t e);
        return {8'(e.dut), 8'(e.kind), e.data, 32'(e.cyc)};
    endfunction

    function automatic string ev_str(ev_t e);
        return $sformatf("dut%0d kind%0d data=%02h cyc%0d", e.dut, e.kind, e.data, e.cyc);
    endfunction

    // Frame outcome from the line rules: stop low wins, then parity by count of ones.
    function automatic int model_kind(int mode, logic [7:0] b, logic pbit, logic stop_bit);
        int ones;
        ones = $countones(b) + ((mode != 0) ? int'(pbit) : 0);
        if (stop_bit == 1'b0) return K_FRAME;
        if (mode == 1 && ones % 2 == 0) return K_PARITY;
        if (mode == 2 && ones % 2 == 1) return K_PARITY;
        return K_VALID;
    endfunction

    // Pulse seen after: 2 sync flops + 1 IDLE cycle + half a bit + 9 (10 with parity) bits.
    function automatic int expect_cyc(int c0, int k);
        return c0 + 3 + CLKS / 2 + ((k != 0) ? 10 : 9) * CLKS;
    endfunction

    task automatic send_frame(input int k, input logic [7:0] b, input logic pbit, input logic stop_bit);
        int c0;
        int kind;
        line_sel = k;
        rxd_v    = 1'b0;
        c0       = cyc;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_v = b[i];
            repeat (CLKS) @(negedge clk);
        end
        if (k != 0) begin
            rxd_v = pbit;
            repeat (CLKS) @(negedge clk);
        end
        rxd_v = stop_bit;
        repeat (CLKS) @(negedge clk);
        kind = model_kind(k, b, pbit, stop_bit);
        if (kind == K_VALID) last_data[k] = b;
        exp_q.push_back('{k, kind, last_data[k], expect_cyc(c0, k)});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({data_w[k], valid_w[k], ferr_w[k], perr_w[k], busy_w[k]} !== 12'h000) begin
                failures++;
                $display("FAIL reset outputs dut%0d: got %03h, want 000", k,
                         {data_w[k], valid_w[k], ferr_w[k], perr_w[k], busy_w[k]});
            end
            last_data[k] = 8'h00;
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({valid_w[k], ferr_w[k], perr_w[k], busy_w[k]} !== 4'h0) begin
                failures++;
                $display("FAIL post-reset idle dut%0d: got %h, want 0", k,
                         {valid_w[k], ferr_w[k], perr_w[k], busy_w[k]});
            end
        end
    endtask

    task automatic test_single();
        ev_q.delete(); exp_q.delete();
        send_frame(0, 8'h41, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL single events: got %0d, want %0d", ev_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (ev_key(ev_q[i]) !== ev_key(exp_q[i])) begin
                failures++;
                $display("FAIL single ev%0d: got %s, want %s", i, ev_str(ev_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        ev_q.delete(); exp_q.delete();
        send_frame(0, 8'h48, 1'b0, 1'b1);
        send_frame(0, 8'h69, 1'b0, 1'b1);
        send_frame(0, 8'h0A, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL back_to_back events: got %0d, want %0d", ev_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (ev_key(ev_q[i]) !== ev_key(exp_q[i])) begin
                failures++;
                $display("FAIL back_to_back ev%0d: got %s, want %s", i, ev_str(ev_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    task automatic test_glitch();
        int busy_cnt;
        ev_q.delete(); exp_q.delete();
        busy_cnt = 0;
        line_sel = 0;
        rxd_v    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 3) rxd_v = 1'b1;
            if (busy_w[0]) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 8) begin
            failures++;
            $display("FAIL glitch busy cycles: got %0d, want 8", busy_cnt);
        end
        checks++;
        if (busy_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL glitch busy after: got %b, want 0", busy_w[0]);
        end
        send_frame(0, 8'h55, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL glitch events: got %0d, want %0d", ev_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (ev_key(ev_q[i]) !== ev_key(exp_q[i])) begin
                failures++;
                $display("FAIL glitch ev%0d: got %s, want %s", i, ev_str(ev_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    task automatic test_frame_err();
        ev_q.delete(); exp_q.delete();
        send_frame(0, 8'hA5, 1'b0, 1'b0);
        rxd_v = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (data_w[0] !== last_data[0]) begin
            failures++;
            $display("FAIL frame_err data hold: got %02h, want %02h", data_w[0], last_data[0]);
        end
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL frame_err events: got %0d, want %0d", ev_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (ev_key(ev_q[i]) !== ev_key(exp_q[i])) begin
                failures++;
                $display("FAIL frame_err ev%0d: got %s, want %s", i, ev_str(ev_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    task automatic test_parity();
        ev_q.delete(); exp_q.delete();
        send_frame(2, 8'h03, 1'b1, 1'b1);
        send_frame(2, 8'h03, 1'b0, 1'b1);
        send_frame(1, 8'h03, 1'b1, 1'b1);
        send_frame(1, 8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL parity events: got %0d, want %0d", ev_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (ev_key(ev_q[i]) !== ev_key(exp_q[i])) begin
                failures++;
                $display("FAIL parity ev%0d: got %s, want %s", i, ev_str(ev_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        ev_q.delete(); exp_q.delete();
        line_sel = 0;
        rxd_v    = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd_v = 1'b1;
            repeat (CLKS) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid busy: got %b, want 0", busy_w[0]);
        end
        checks++;
        if (data_w[0] !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid data: got %02h, want 00", data_w[0]);
        end
        for (int k = 0; k < 3; k++) last_data[k] = 8'h00;
        repeat (5 * CLKS - 1) @(negedge clk);
        send_frame(0, 8'h12, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL reset_mid events: got %0d, want %0d", ev_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (ev_key(ev_q[i]) !== ev_key(exp_q[i])) begin
                failures++;
                $display("FAIL reset_mid ev%0d: got %s, want %s", i, ev_str(ev_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    task automatic test_break();
        int c0;
        ev_q.delete(); exp_q.delete();
        line_sel = 0;
        rxd_v    = 1'b0;
        c0       = cyc;
        exp_q.push_back('{0, K_FRAME, last_data[0], expect_cyc(c0, 0)});
        repeat (30 * CLKS) @(negedge clk);
        checks++;
        if (busy_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL break busy while low: got %b, want 0", busy_w[0]);
        end
        rxd_v = 1'b1;
        repeat (2 * CLKS) @(negedge clk);
        send_frame(0, 8'h7E, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL break events: got %0d, want %0d", ev_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (ev_key(ev_q[i]) !== ev_key(exp_q[i])) begin
                failures++;
                $display("FAIL break ev%0d: got %s, want %s", i, ev_str(ev_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    task automatic test_random();
        int         k;
        logic [7:0] b;
        logic       pbit;
        logic       stop_bit;
        ev_q.delete(); exp_q.delete();
        for (int n = 0; n < 40; n++) begin
            k        = int'($urandom_range(0, 2));
            b        = 8'($urandom);
            pbit     = 1'($urandom_range(0, 1));
            stop_bit = ($urandom_range(0, 7) != 0);
            send_frame(k, b, pbit, stop_bit);
            rxd_v = 1'b1;
            repeat (stop_bit ? $urandom_range(0, 6) : $urandom_range(3, 8)) @(negedge clk);
        end
        repeat (CLKS) @(negedge clk);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random events: got %0d, want %0d", ev_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (ev_key(ev_q[i]) !== ev_key(exp_q[i])) begin
                failures++;
                $display("FAIL random ev%0d: got %s, want %s", i, ev_str(ev_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_parity();
        test_reset_mid();
        test_break();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
